// File: rtl/rf_scoreboard.sv
// rf_scoreboard
// Multi-read-port register file for the pipelined RV32I core. It combines the
// architectural x0..x(2**ADDRESS_WIDTH-1) storage with a per-register count of
// in-flight producers, so decode can see whether each source is still pending.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears data and counts
//   wr_en      write strobe (also retires one pending producer of wa)
//   wa, din    write address / data
//   ra         NUM_RD packed read addresses, port k at [k*ADDRESS_WIDTH +: ADDRESS_WIDTH]
//   rdata      NUM_RD packed read data, same packing, combinational
//   rbusy      per port: source still has an outstanding producer
//   iss_en     decode issues an instruction writing iss_rd
//   iss_rd     destination of the issued instruction
//   iss_stall  issue refused because the count for iss_rd is saturated
//   a0         debug tap of x10 (stored value, never bypassed)
module rf_scoreboard #(
    parameter int D_WIDTH       = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_RD        = 2,
    parameter int CNT_W         = 2,
    parameter int BYPASS        = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [ADDRESS_WIDTH-1:0]          wa,
    input  logic [D_WIDTH-1:0]                din,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0]   ra,
    output logic [NUM_RD*D_WIDTH-1:0]         rdata,
    output logic [NUM_RD-1:0]                 rbusy,
    input  logic                              iss_en,
    input  logic [ADDRESS_WIDTH-1:0]          iss_rd,
    output logic                              iss_stall,
    output logic [D_WIDTH-1:0]                a0
);

    localparam int                     DEPTH   = 2 ** ADDRESS_WIDTH;
    localparam logic [CNT_W-1:0]       CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]       CNT_ONE = CNT_W'(1);
    localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);

    logic [D_WIDTH-1:0] regs_q [DEPTH];
    logic [D_WIDTH-1:0] regs_d [DEPTH];
    logic [CNT_W-1:0]   cnt_q  [DEPTH];
    logic [CNT_W-1:0]   cnt_d  [DEPTH];

    logic               wr_valid_s;
    logic               iss_stall_s;
    logic               iss_take_s;

    assign wr_valid_s = wr_en && (wa != '0);

    // Issue refusal: saturated count, unless a write to the same register
    // retires a producer on this very edge and frees a slot.
    always_comb begin
        iss_stall_s = 1'b0;
        if (iss_en && (iss_rd != '0) && (cnt_q[iss_rd] == CNT_MAX)
            && !(wr_en && (wa == iss_rd))) begin
            iss_stall_s = 1'b1;
        end else begin
            iss_stall_s = 1'b0;
        end
    end

    assign iss_stall  = iss_stall_s;
    assign iss_take_s = iss_en && (iss_rd != '0) && !iss_stall_s;

    // Next-state data: a valid write replaces one entry, x0 is never written.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            regs_d[r] = (wr_valid_s && (wa == ADDRESS_WIDTH'(r))) ? din : regs_q[r];
        end
    end

    // Next-state counts: accepted issue increments, retiring write decrements
    // (only when non-zero so a stray write cannot underflow); both cancel.
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                case ({iss_take_s && (iss_rd == ADDRESS_WIDTH'(r)),
                       wr_en && (wa == ADDRESS_WIDTH'(r)) && (cnt_q[r] != '0)})
                    2'b10:   cnt_d[r] = cnt_q[r] + CNT_ONE;
                    2'b01:   cnt_d[r] = cnt_q[r] - CNT_ONE;
                    default: cnt_d[r] = cnt_q[r];
                endcase
            end else begin
                cnt_d[r] = '0;
            end
        end
    end

    // State registers for data and pending counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= regs_d[r];
                cnt_q[r]  <= cnt_d[r];
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] ra_k_s;
        logic                     hit_k_s;
        logic [D_WIDTH-1:0]       rdata_k_s;
        logic                     rbusy_k_s;

        assign ra_k_s  = ra[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign hit_k_s = (BYPASS != 0) && wr_en && (wa == ra_k_s) && (ra_k_s != '0);

        // Read port: x0 reads as idle zero; a bypass hit forwards din and
        // hides busy when the retiring write is the last pending producer.
        always_comb begin
            rdata_k_s = '0;
            rbusy_k_s = 1'b0;
            if (ra_k_s == '0) begin
                rdata_k_s = '0;
                rbusy_k_s = 1'b0;
            end else if (hit_k_s) begin
                rdata_k_s = din;
                rbusy_k_s = (cnt_q[ra_k_s] != '0) && (cnt_q[ra_k_s] != CNT_ONE);
            end else begin
                rdata_k_s = regs_q[ra_k_s];
                rbusy_k_s = (cnt_q[ra_k_s] != '0);
            end
        end

        assign rdata[k*D_WIDTH +: D_WIDTH] = rdata_k_s;
        assign rbusy[k]                    = rbusy_k_s;
    end

    assign a0 = regs_q[A0_IDX];

endmodule

// File: tb/tb_rf_scoreboard.sv
// Bench for rf_scoreboard: one instance with forwarding, one without, driven
// by the same directed vectors. A reference model of the register file and
// pending counts is compared against both every cycle; literal checks pin the
// scenarios by hand.
module tb_rf_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wa;
    logic [31:0] din;
    logic [9:0]  ra;
    logic        iss_en;
    logic [4:0]  iss_rd;

    logic [63:0] rdata_b1, rdata_b0;
    logic [1:0]  rbusy_b1, rbusy_b0;
    logic        stall_b1, stall_b0;
    logic [31:0] a0_b1, a0_b0;

    int n_cmp = 0;
    int n_err = 0;

    rf_scoreboard #(.D_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_RD(2), .CNT_W(2), .BYPASS(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wa(wa), .din(din), .ra(ra),
        .rdata(rdata_b1), .rbusy(rbusy_b1), .iss_en(iss_en), .iss_rd(iss_rd),
        .iss_stall(stall_b1), .a0(a0_b1));

    rf_scoreboard #(.D_WIDTH(32), .ADDRESS_WIDTH(5), .NUM_RD(2), .CNT_W(2), .BYPASS(0)) u_b0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wa(wa), .din(din), .ra(ra),
        .rdata(rdata_b0), .rbusy(rbusy_b0), .iss_en(iss_en), .iss_rd(iss_rd),
        .iss_stall(stall_b0), .a0(a0_b0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] m_reg [32];
    int          m_cnt [32];

    function automatic bit m_stall();
        return iss_en && (iss_rd != 5'd0) && (m_cnt[iss_rd] == 3)
               && !(wr_en && (wa == iss_rd));
    endfunction

    function automatic logic [31:0] m_rdata(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (byp && wr_en && (wa == a)) return din;
        return m_reg[a];
    endfunction

    function automatic bit m_busy(input bit byp, input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (byp && wr_en && (wa == a) && (m_cnt[a] == 1)) return 1'b0;
        return m_cnt[a] > 0;
    endfunction

    // Model state advances on each clock edge; reset clears it at once.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[r] = 32'd0;
                m_cnt[r] = 0;
            end
        end else begin
            bit stall_now;
            stall_now = m_stall();
            if (wr_en && (wa != 5'd0)) begin
                m_reg[wa] = din;
                if (m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
            end
            if (iss_en && (iss_rd != 5'd0) && !stall_now)
                m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                logic [4:0] a;
                a = ra[k*5 +: 5];
                chk($sformatf("m_rdata_byp%0d", k), rdata_b1[k*32 +: 32], m_rdata(1'b1, a));
                chk($sformatf("m_rbusy_byp%0d", k), {31'd0, rbusy_b1[k]}, {31'd0, m_busy(1'b1, a)});
                chk($sformatf("m_rdata_nob%0d", k), rdata_b0[k*32 +: 32], m_rdata(1'b0, a));
                chk($sformatf("m_rbusy_nob%0d", k), {31'd0, rbusy_b0[k]}, {31'd0, m_busy(1'b0, a)});
            end
            chk("m_stall_byp", {31'd0, stall_b1}, {31'd0, m_stall()});
            chk("m_stall_nob", {31'd0, stall_b0}, {31'd0, m_stall()});
            chk("m_a0_byp", a0_b1, m_reg[10]);
            chk("m_a0_nob", a0_b0, m_reg[10]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wa = 5'd0; din = 32'd0; iss_en = 1'b0; iss_rd = 5'd0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = 32'd0;
            m_cnt[r] = 0;
        end
        rst_n = 1'b0;
        idle();
        ra = 10'd0;
        tick();
        tick();
        ra = {5'd10, 5'd5};
        #1;
        chk("rst_rdata", rdata_b1[31:0], 32'd0);
        chk("rst_rbusy", {30'd0, rbusy_b1}, 32'd0);
        chk("rst_stall", {31'd0, stall_b1}, 32'd0);
        chk("rst_a0", a0_b1, 32'd0);
        rst_n = 1'b1;

        // write x5 with same-cycle read on both ports
        tick();
        wr_en = 1'b1; wa = 5'd5; din = 32'hDEADBEEF; ra = {5'd5, 5'd5};
        #1;
        chk("byp_p0", rdata_b1[31:0], 32'hDEADBEEF);
        chk("byp_p1", rdata_b1[63:32], 32'hDEADBEEF);
        chk("nob_same", rdata_b0[31:0], 32'd0);
        tick();
        idle();
        #1;
        chk("nob_next", rdata_b0[63:32], 32'hDEADBEEF);

        // x0 write and issue are ignored
        wr_en = 1'b1; wa = 5'd0; din = 32'hFFFFFFFF; iss_en = 1'b1; iss_rd = 5'd0;
        ra = {5'd0, 5'd0};
        #1;
        chk("x0_rdata", rdata_b1[31:0], 32'd0);
        chk("x0_stall", {31'd0, stall_b1}, 32'd0);
        tick();
        idle();
        #1;
        chk("x0_rbusy", {30'd0, rbusy_b1}, 32'd0);

        // saturate x7
        ra = {5'd0, 5'd7};
        iss_en = 1'b1; iss_rd = 5'd7;
        #1;
        chk("iss_same_cycle", {31'd0, rbusy_b1[0]}, 32'd0);
        tick();
        chk("iss_busy_next", {31'd0, rbusy_b1[0]}, 32'd1);
        tick();
        tick();
        chk("sat_stall", {31'd0, stall_b1}, 32'd1);
        tick();
        wr_en = 1'b1; wa = 5'd7; din = 32'h77;
        #1;
        chk("sat_wr_accept", {31'd0, stall_b1}, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("sat_still3", {31'd0, stall_b1}, 32'd1);

        // drain x7: 3 -> 2 -> 1, then last write retires
        iss_en = 1'b0; wr_en = 1'b1; wa = 5'd7; din = 32'h21;
        tick();
        din = 32'h22;
        tick();
        din = 32'h12;
        #1;
        chk("last_byp_rdata", rdata_b1[31:0], 32'h12);
        chk("last_byp_busy", {31'd0, rbusy_b1[0]}, 32'd0);
        chk("last_nob_busy", {31'd0, rbusy_b0[0]}, 32'd1);
        chk("last_nob_rdata", rdata_b0[31:0], 32'h22);
        tick();
        idle();
        #1;
        chk("drain_nob_busy", {31'd0, rbusy_b0[0]}, 32'd0);
        chk("drain_nob_rdata", rdata_b0[31:0], 32'h12);

        // a0 tap
        wr_en = 1'b1; wa = 5'd10; din = 32'h1234;
        #1;
        chk("a0_same", a0_b1, 32'd0);
        tick();
        idle();
        #1;
        chk("a0_next", a0_b1, 32'h1234);

        // x3: data 0x55, count 2, then async reset pulse
        wr_en = 1'b1; wa = 5'd3; din = 32'h55; ra = {5'd3, 5'd0};
        tick();
        idle();
        iss_en = 1'b1; iss_rd = 5'd3;
        tick();
        tick();
        idle();
        #1;
        chk("x3_busy", {31'd0, rbusy_b1[1]}, 32'd1);
        chk("x3_rdata", rdata_b1[63:32], 32'h55);
        rst_n = 1'b0;
        #1;
        chk("arst_rdata", rdata_b1[63:32], 32'd0);
        chk("arst_busy", {30'd0, rbusy_b1}, 32'd0);
        chk("arst_a0", a0_b1, 32'd0);
        rst_n = 1'b1;
        tick();
        wr_en = 1'b1; wa = 5'd3; din = 32'h66;
        #1;
        chk("post_byp_rdata", rdata_b1[63:32], 32'h66);
        chk("post_byp_busy", {31'd0, rbusy_b1[1]}, 32'd0);
        tick();
        idle();
        #1;
        chk("no_underflow", {30'd0, rbusy_b0}, 32'd0);
        chk("post_nob_rdata", rdata_b0[63:32], 32'h66);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised multi-read-port register file with write-first bypass and per-register pending-write scoreboard, for the pipelined RV32I core. It replaces the single-cycle core's two-port register file. It holds the architectural x0–x31 state and tells decode, per read port, whether a source register still awaits an in-flight producer. Reads are combinational. Writes and scoreboard updates are on the rising clock edge.

## Interface
- D_WIDTH, 32: register data width.
- ADDRESS_WIDTH, 5: register index width; depth is 2**ADDRESS_WIDTH.
- NUM_RD, 2: number of read ports (1–4).
- CNT_W, 2: width of per-register outstanding-write counter.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports; 0 = no forwarding.

- clk  in  1  clock, rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe.
- wa  in  ADDRESS_WIDTH  write address.
- din  in  D_WIDTH  write data.
- ra  in  NUM_RD*ADDRESS_WIDTH  read addresses; port k occupies bits [k*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- rdata  out  NUM_RD*D_WIDTH  read data, packed the same way.
- rbusy  out  NUM_RD  port k source has an outstanding producer.
- iss_en  in  1  decode issues an instruction that will write iss_rd.
- iss_rd  in  ADDRESS_WIDTH  destination of the issued instruction.
- iss_stall  out  1  issue refused: counter for iss_rd saturated.
- a0  out  D_WIDTH  debug tap, always x10.

## Operation
- Storage: 2**ADDRESS_WIDTH × D_WIDTH registers.
- Counters: one CNT_W-bit counter cnt[r] per register.
- x0:
  - Reads always return 0.
  - Writes to x0 are ignored.
  - Issues to x0 are ignored; cnt[0] stays 0.
  - rbusy for x0 is always 0.
- Write: when wr_en is high and wa != 0, reg[wa] <= din on the rising edge.
- Read port k, combinational:
  - If BYPASS=1, wr_en=1, wa=ra_k and ra_k != 0: rdata_k = din.
  - Otherwise: rdata_k = reg[ra_k].
- Scoreboard update per rising edge, for register r != 0:
  - inc = iss_en & (iss_rd==r) & ~iss_stall.
  - dec = wr_en & (wa==r) & (cnt[r]!=0).
  - inc & ~dec: cnt+1. dec & ~inc: cnt-1. Both or neither: unchanged.
  - A write to a register whose count is 0 still updates data; cnt stays 0 (no underflow).
- iss_stall = iss_en & (iss_rd != 0) & (cnt[iss_rd] == 2**CNT_W-1) & ~(wr_en & wa==iss_rd).
  - A same-cycle retiring write frees a slot, so the issue is accepted.
- rbusy_k = (cnt[ra_k] != 0), except forced 0 when BYPASS=1, wr_en=1, wa=ra_k and cnt[ra_k]==1.
  - The last producer is retiring this cycle, and its data is on rdata_k.
- A read port whose address matches a same-cycle iss_rd is not affected by that issue in the current cycle.
- a0 = reg[10], no bypass.

## Timing
- Read latency: 0 cycles (combinational from ra, wa, din, wr_en and state).
- Write-to-read latency:
  - BYPASS=1: 0 cycles (same cycle).
  - BYPASS=0: data visible the cycle after the write edge.
- Issue-to-busy: rbusy asserts the cycle after the accepted iss_en edge.
- Reset (rst_n low, asynchronous):
  - All registers cleared to 0; all counters cleared to 0.
  - Hence rdata = 0, rbusy = 0, a0 = 0, iss_stall = 0 while reset holds.
- Reset mid-operation discards all pending counts. No write or issue takes effect on any edge where rst_n is low.
- Deassertion is synchronised externally. The first active edge is the first rising edge with rst_n high.

## Test plan
- Reset, then write x5 = 0xDEADBEEF and read it on ports 0 and 1 in the same cycle → both ports return 0xDEADBEEF with BYPASS=1. With BYPASS=0 they return 0 that cycle and 0xDEADBEEF next cycle.
- Write x0 = 0xFFFFFFFF, issue x0 → reading x0 returns 0, rbusy = 0, iss_stall = 0.
- Issue x7 three times over three cycles (CNT_W=2) → rbusy on x7 set from cycle 1. A fourth issue gives iss_stall = 1 and the count stays 3. A fourth issue in the same cycle as a write to x7 is accepted and the count stays 3.
- Count of x7 = 1, then write x7 = 0x12 while reading x7 → rdata = 0x12 and rbusy = 0 that cycle (BYPASS=1). With BYPASS=0, rbusy = 1 that cycle and 0 the next.
- Write x10 = 0x1234 → a0 = 0x1234 the cycle after the edge.
- With x3 count = 2 and reg x3 = 0x55, pulse rst_n low between edges → asynchronously rdata = 0 and rbusy = 0. After release, a write to x3 leaves the count at 0 (no underflow).
